vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: the successor to the fixed 1024x768 timing block. Geometry, sync polarity and counter widths are parameters. A pixel clock-enable, a resync input, a data-enable output and line/frame start strobes are added. It sits at the head of the video pipeline and drives the background, sprite and overlay stages with coherent, registered count and control signals.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers.
// The XGA constants are the default geometry of the raster generator.
// Downstream stages import this package so they agree on the same frame.
package vga_pkg;

    // Default XGA 1024x768 horizontal geometry, in pixels
    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FRONT  = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BACK   = 160;
    localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FRONT + XGA_H_SYNC + XGA_H_BACK;

    // Default XGA 1024x768 vertical geometry, in lines
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FRONT  = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BACK   = 29;
    localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FRONT + XGA_V_SYNC + XGA_V_BACK;

    // Sync polarity encodings: the level a sync output takes while asserted
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Number of bits needed to hold the values 0 .. total-1
    function automatic int count_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the video pipeline.
// The master side is the generator: it takes ce/resync and drives the raster.
// The slave side is the pipeline head: it supplies ce/resync and consumes the raster.
interface vga_timing_gen_if #(
    parameter int HW = 11,
    parameter int VW = 10
);
    logic          ce;
    logic          resync;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          hblnk;
    logic          vblnk;
    logic          de;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  ce, resync,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
    );

    modport slave (
        output ce, resync,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with registered blank and sync.
// Flags are derived from the next count so they change on the same edge as
// the count. That gives them zero skew against it.
module vga_axis_counter #(
    parameter int   ACTIVE = 1024,
    parameter int   FRONT  = 24,
    parameter int   SYNC   = 136,
    parameter int   BACK   = 160,
    parameter logic POL    = 1'b0,
    parameter int   W      = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         blank_o,
    output logic         sync_o,
    output logic         blank_next_o
);
    localparam int           TOTAL      = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FRONT);
    // Inclusive upper bound keeps the constant inside W bits even when BACK is 0
    localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FRONT + SYNC - 1);

    logic [W-1:0] count_q, count_d;
    logic         blank_q, blank_d;
    logic         sync_q,  sync_d;

    // Wrap means the next advance returns this axis to 0
    assign wrap_o = (count_q == LAST);

    // Next count; clear (resync) beats the normal increment
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = wrap_o ? '0 : count_q + W'(1);
        end
        blank_d = (count_d >= ACT_END);
        sync_d  = ((count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST)) ? POL : ~POL;
    end

    // Register the count and the flags that describe it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= ~POL;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o      = count_q;
    assign blank_o      = blank_q;
    assign sync_o       = sync_q;
    assign blank_next_o = blank_d;
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator at the head of the video pipeline.
// It chains a horizontal and a vertical axis counter. It then registers
// data-enable and the line/frame start strobes against the same next-state.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = XGA_H_ACTIVE,
    parameter int   H_FRONT   = XGA_H_FRONT,
    parameter int   H_SYNC    = XGA_H_SYNC,
    parameter int   H_BACK    = XGA_H_BACK,
    parameter int   V_ACTIVE  = XGA_V_ACTIVE,
    parameter int   V_FRONT   = XGA_V_FRONT,
    parameter int   V_SYNC    = XGA_V_SYNC,
    parameter int   V_BACK    = XGA_V_BACK,
    parameter logic HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic VSYNC_POL = SYNC_ACTIVE_LOW,
    parameter int   HW        = count_width(XGA_H_TOTAL),
    parameter int   VW        = count_width(XGA_V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst,
    vga_timing_gen_if.master vid
);
    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          h_wrap, v_wrap;
    logic          h_blank, v_blank;
    logic          h_blank_next, v_blank_next;
    logic          h_sync, v_sync;
    logic          h_clear, v_advance;

    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          de_q, de_d;

    // Resync only acts on a pixel advance and pulls both axes to 0
    assign h_clear   = vid.ce & vid.resync;
    assign v_advance = vid.ce & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .POL    (HSYNC_POL),
        .W      (HW)
    ) u_h_axis (
        .clk          (clk),
        .rst          (rst),
        .advance_i    (vid.ce),
        .clear_i      (h_clear),
        .count_o      (h_count),
        .wrap_o       (h_wrap),
        .blank_o      (h_blank),
        .sync_o       (h_sync),
        .blank_next_o (h_blank_next)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .POL    (VSYNC_POL),
        .W      (VW)
    ) u_v_axis (
        .clk          (clk),
        .rst          (rst),
        .advance_i    (v_advance),
        .clear_i      (h_clear),
        .count_o      (v_count),
        .wrap_o       (v_wrap),
        .blank_o      (v_blank),
        .sync_o       (v_sync),
        .blank_next_o (v_blank_next)
    );

    // Strobes and data-enable for the position being entered; all hold while ce=0
    always_comb begin
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        de_d          = ~h_blank_next & ~v_blank_next;
        if (vid.ce) begin
            line_start_d  = vid.resync | h_wrap;
            frame_start_d = vid.resync | (h_wrap & v_wrap);
        end
    end

    // Register strobes and data-enable alongside the axis counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            de_q          <= 1'b1;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            de_q          <= de_d;
        end
    end

    assign vid.hcount      = h_count;
    assign vid.vcount      = v_count;
    assign vid.hsync       = h_sync;
    assign vid.vsync       = v_sync;
    assign vid.hblnk       = h_blank;
    assign vid.vblnk       = v_blank;
    assign vid.de          = de_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for the VGA raster generator in a small 14x7 mode.
// A position-level reference model predicts every output on every clock.
module tb_vga_timing_gen;
    localparam int   HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int   VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int   HT = HA + HF + HS + HB;   // 14
    localparam int   VT = VA + VF + VS + VB;   // 7
    localparam int   HWB = 4, VWB = 3;
    localparam logic HPOL = 1'b1, VPOL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.HW(HWB), .VW(VWB)) vif ();

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .HSYNC_POL (HPOL), .VSYNC_POL (VPOL),
        .HW (HWB), .VW (VWB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vid (vif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raster position plus the two strobes
    int mh = 0, mv = 0;
    bit mls = 1'b0, mfs = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", tag, obs, exp, mh, mv);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mls = 1'b0; mfs = 1'b0;
    endtask

    task automatic model_advance(input bit rs);
        if (rs) begin
            mh = 0; mv = 0; mls = 1'b1; mfs = 1'b1;
        end else begin
            mh = (mh + 1) % HT;
            if (mh == 0) mv = (mv + 1) % VT;
            mls = (mh == 0);
            mfs = (mh == 0) && (mv == 0);
        end
    endtask

    task automatic check_all(input string ph);
        bit ehb, evb, ehs, evs;
        ehb = (mh >= HA);
        evb = (mv >= VA);
        ehs = (mh >= HA + HF && mh < HA + HF + HS) ? HPOL : !HPOL;
        evs = (mv >= VA + VF && mv < VA + VF + VS) ? VPOL : !VPOL;
        check({ph, ".hcount"},      32'(vif.hcount),      32'(mh));
        check({ph, ".vcount"},      32'(vif.vcount),      32'(mv));
        check({ph, ".hblnk"},       32'(vif.hblnk),       32'(ehb));
        check({ph, ".vblnk"},       32'(vif.vblnk),       32'(evb));
        check({ph, ".de"},          32'(vif.de),          32'(!ehb && !evb));
        check({ph, ".hsync"},       32'(vif.hsync),       32'(ehs));
        check({ph, ".vsync"},       32'(vif.vsync),       32'(evs));
        check({ph, ".line_start"},  32'(vif.line_start),  32'(mls));
        check({ph, ".frame_start"}, 32'(vif.frame_start), 32'(mfs));
    endtask

    task automatic step(input bit c, input bit rs, input string ph);
        @(negedge clk);
        vif.ce = c;
        vif.resync = rs;
        @(posedge clk);
        if (c) model_advance(rs);
        #1;
        check_all(ph);
    endtask

    task automatic check_reset_values(input string ph);
        check({ph, ".hcount"},      32'(vif.hcount),      32'd0);
        check({ph, ".vcount"},      32'(vif.vcount),      32'd0);
        check({ph, ".hblnk"},       32'(vif.hblnk),       32'd0);
        check({ph, ".vblnk"},       32'(vif.vblnk),       32'd0);
        check({ph, ".de"},          32'(vif.de),          32'd1);
        check({ph, ".hsync"},       32'(vif.hsync),       32'(!HPOL));
        check({ph, ".vsync"},       32'(vif.vsync),       32'(!VPOL));
        check({ph, ".line_start"},  32'(vif.line_start),  32'd0);
        check({ph, ".frame_start"}, 32'(vif.frame_start), 32'd0);
    endtask

    initial begin
        int n_ls, n_fs, n_de;
        vif.ce = 1'b0;
        vif.resync = 1'b0;

        // Reset held: outputs at reset values, then release away from the edge
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b1, "idle");
        $display("phase reset: checks=%0d failures=%0d", n_checks, n_fail);

        // First ce moves to (1,0)
        step(1'b1, 1'b0, "first");
        check("first_ce_h", 32'(vif.hcount), 32'd1);

        // Free-running ce for two frames, counting strobes over one whole frame
        n_ls = 0; n_fs = 0; n_de = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step(1'b1, 1'b0, "run");
            if (i >= HT * VT) begin
                n_ls += int'(vif.line_start);
                n_fs += int'(vif.frame_start);
                n_de += int'(vif.de);
            end
        end
        check("frame_line_starts",  32'(n_ls), 32'd7);
        check("frame_frame_starts", 32'(n_fs), 32'd1);
        check("frame_de_pixels",    32'(n_de), 32'd32);
        $display("phase run: checks=%0d failures=%0d", n_checks, n_fail);

        // ce toggling: a frame takes twice as many clocks and strobes hold through ce=0
        n_fs = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step(1'((i % 2) == 0), 1'b0, "toggle");
            n_fs += int'(vif.frame_start);
        end
        check("toggle_frame_start_clocks", 32'(n_fs), 32'd2);
        $display("phase toggle: checks=%0d failures=%0d", n_checks, n_fail);

        // Resync at (5,3): ignored with ce=0, forces (0,0) with both strobes when ce=1
        for (int i = 0; i < 2 * HT * VT && !(mh == 5 && mv == 3); i++) step(1'b1, 1'b0, "seek");
        check("resync_reach_h", 32'(vif.hcount), 32'd5);
        check("resync_reach_v", 32'(vif.vcount), 32'd3);
        step(1'b0, 1'b1, "resync_ce0");
        check("resync_ce0_h", 32'(vif.hcount), 32'd5);
        step(1'b1, 1'b0, "resync_not_latched");
        check("resync_not_latched_h", 32'(vif.hcount), 32'd6);
        step(1'b1, 1'b1, "resync");
        check("resync_h",  32'(vif.hcount),      32'd0);
        check("resync_v",  32'(vif.vcount),      32'd0);
        check("resync_ls", 32'(vif.line_start),  32'd1);
        check("resync_fs", 32'(vif.frame_start), 32'd1);
        $display("phase resync: checks=%0d failures=%0d", n_checks, n_fail);

        // Randomized ce and resync against the model
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0), "rand");
        end
        $display("phase random: checks=%0d failures=%0d", n_checks, n_fail);

        // Async reset between edges mid-line: outputs return before the next edge
        for (int i = 0; i < 2 * HT && mh != 7; i++) step(1'b1, 1'b0, "seek7");
        check("rst_mid_h", 32'(vif.hcount), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        vif.ce = 1'b0;
        vif.resync = 1'b0;
        step(1'b1, 1'b0, "post_rst");
        check("post_rst_h", 32'(vif.hcount), 32'd1);
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0), "rand2");
        end
        $display("phase async_reset: checks=%0d failures=%0d", n_checks, n_fail);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
